// File: rtl/iccm_prog_ctrl.sv
// -----------------------------------------------------------------------------
// iccm_prog_ctrl
//
// Programming-side controller for the instruction memory (ICCM). A little-endian
// byte stream from the boot/UART receiver is packed into 32-bit words. Each
// completed word is written to the memory's programming port with a one-cycle
// write strobe. While programming is active the core/fabric is held off through
// prog_rst_no. A word equal to EndMarker ends programming and is never written;
// the memory is then handed back to the TL-UL path.
//
// Optional feature (compile-time macro): ICCM_PROG_TIMEOUT_EN
//   When defined, an idle-byte counter runs in PROG. After TimeoutCycles cycles
//   with no received byte, programming is abandoned: the partial word is
//   dropped, the block returns to RUN and err_o is set.
//   When undefined, PROG waits for bytes indefinitely.
//
// Parameters
//   AddrW         word address width of the programming port
//   EndMarker     assembled word that terminates programming
//   BootInProg    1: start in PROG out of reset, 0: start in RUN
//   TimeoutCycles idle-byte timeout in clk_i cycles (timeout build only)
//
// Ports
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   prog_req_i   one-cycle request to re-enter programming; honoured only in RUN
//   rx_byte_i    received program byte
//   rx_valid_i   rx_byte_i is valid for this cycle only (no backpressure)
//   we_o         programming write strobe, one cycle per word
//   addr_o       word address of the current write
//   wdata_o      assembled word
//   prog_rst_no  0: programming owns the memory and the core is held, 1: run
//   busy_o       1 while in PROG or WRITE
//   err_o        sticky error: address wrap, or timeout when enabled
//
// Handshake: the receiver side is a pure valid strobe. Every cycle with
// rx_valid_i=1 in PROG or WRITE transfers exactly one byte; there is no ready,
// so the controller must accept a byte in every such cycle, including the
// WRITE cycle. Bytes presented in RUN are dropped. The write side is a bare
// strobe: the memory takes addr_o/wdata_o in every cycle where we_o=1.
//
// State visibility: the FSM state is fully observable at the ports, since
// RUN <=> prog_rst_no=1, WRITE <=> we_o=1, PROG <=> busy_o=1 and we_o=0.
// -----------------------------------------------------------------------------
module iccm_prog_ctrl #(
  parameter int unsigned AddrW         = 12,
  parameter logic [31:0] EndMarker     = 32'h0000_0FFF,
  parameter logic        BootInProg    = 1'b1,
  parameter logic [23:0] TimeoutCycles = 24'd1_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             prog_req_i,
  input  logic [7:0]       rx_byte_i,
  input  logic             rx_valid_i,
  output logic             we_o,
  output logic [AddrW-1:0] addr_o,
  output logic [31:0]      wdata_o,
  output logic             prog_rst_no,
  output logic             busy_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PROG  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam state_e          ResetState = BootInProg ? ST_PROG : ST_RUN;
  localparam logic [AddrW-1:0] AddrMax   = {AddrW{1'b1}};

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  // Only the first three bytes need storage; the fourth byte is taken
  // straight from rx_byte_i when the word completes.
  logic [23:0]      word_q, word_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic             err_q, err_d;
  logic             we_q, busy_q, run_q;
  logic [31:0]      full_word;

`ifdef ICCM_PROG_TIMEOUT_EN
  logic [23:0]      tmo_q, tmo_d;
`else
  logic             unused_tmo;
  assign unused_tmo = ^TimeoutCycles;
`endif

  assign full_word = {rx_byte_i, word_q};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    err_d   = err_q;
`ifdef ICCM_PROG_TIMEOUT_EN
    tmo_d   = '0;
`endif

    unique case (state_q)
      ST_RUN: begin
        if (prog_req_i) begin
          state_d = ST_PROG;
          addr_d  = '0;
          cnt_d   = '0;
          word_d  = '0;
          err_d   = 1'b0;
        end
      end

      ST_PROG, ST_WRITE: begin
        // The write strobe lasts one cycle; the address advances as it ends.
        if (state_q == ST_WRITE) begin
          state_d = ST_PROG;
          addr_d  = addr_q + AddrW'(1);
          if (addr_q == AddrMax) begin
            err_d = 1'b1;
          end
        end

        // Byte intake is shared by PROG and WRITE so that a byte arriving in
        // the WRITE cycle becomes byte 0 of the next word. The count is always
        // 0 in WRITE, so a word can only complete from PROG.
        if (rx_valid_i) begin
          if (cnt_q == 2'd3) begin
            cnt_d  = '0;
            word_d = '0;
            if (full_word == EndMarker) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_WRITE;
              wdata_d = full_word;
            end
          end else begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
              2'd0:    word_d[7:0]   = rx_byte_i;
              2'd1:    word_d[15:8]  = rx_byte_i;
              2'd2:    word_d[23:16] = rx_byte_i;
              default: word_d        = word_q;
            endcase
          end
        end

`ifdef ICCM_PROG_TIMEOUT_EN
        // Idle counter runs only in PROG and restarts on every byte.
        if (state_q == ST_PROG && !rx_valid_i) begin
          if (tmo_q == TimeoutCycles - 24'd1) begin
            state_d = ST_RUN;
            err_d   = 1'b1;
            cnt_d   = '0;
            word_d  = '0;
          end else begin
            tmo_d = tmo_q + 24'd1;
          end
        end
`endif
      end

      default: begin
        state_d = ResetState;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= BootInProg;
      run_q   <= ~BootInProg;
`ifdef ICCM_PROG_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      // State-decoded outputs are registered from the next state so they
      // change on the same edge as the state and never glitch.
      we_q    <= (state_d == ST_WRITE);
      busy_q  <= (state_d != ST_RUN);
      run_q   <= (state_d == ST_RUN);
`ifdef ICCM_PROG_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign prog_rst_no = run_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_iccm_prog_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for iccm_prog_ctrl. Inputs are driven on the falling edge; outputs
// are sampled on the falling edge or 1 time unit after the rising edge.
// A byte-stream reference model turns accepted bytes into expected writes
// ({err, addr, data}) on exp_q; a monitor pops one entry per we_o pulse.
// -----------------------------------------------------------------------------
module tb_iccm_prog_ctrl;

  localparam int          AW = 12;
  localparam logic [31:0] EM = 32'h0000_0FFF;
  localparam logic [23:0] TO = 24'd40;
  localparam int          EW = AW + 33;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_req = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_valid = 1'b0;
  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o;
  logic          prog_rst_no;
  logic          busy_o;
  logic          err_o;

  always #5 clk = ~clk;

  iccm_prog_ctrl #(
    .AddrW        (AW),
    .EndMarker    (EM),
    .BootInProg   (1'b1),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .prog_req_i (prog_req),
    .rx_byte_i  (rx_byte),
    .rx_valid_i (rx_valid),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .prog_rst_no(prog_rst_no),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int            total = 0;
  int            bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0]    m_bytes[$];
  bit            m_run;
  bit            m_err;
  int            m_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_err  = 1'b0;
    m_addr = 0;
    m_bytes.delete();
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    m_bytes.push_back(b);
    if (m_bytes.size() == 4) begin
      w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
      m_bytes.delete();
      if (w == EM) begin
        m_run = 1'b1;
      end else begin
        exp_q.push_back({m_err, AW'(m_addr), w});
        if (m_addr == (1 << AW) - 1) m_err = 1'b1;
        m_addr = (m_addr + 1) % (1 << AW);
      end
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && we_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL write_unexpected act=%h/%h exp=none t=%0t", addr_o, wdata_o, $time);
      end else begin
        chk("write", {err_o, addr_o, wdata_o}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [7:0] b, input logic r);
    bit was_run;
    @(negedge clk);
    rx_valid = v;
    rx_byte  = b;
    prog_req = r;
    was_run  = m_run;
    if (v && !was_run) model_byte(b);
    if (r && was_run) begin
      m_run  = 1'b0;
      m_addr = 0;
      m_err  = 1'b0;
      m_bytes.delete();
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit allow_req, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, maxgap)) drive(1'b0, 8'h00, 1'b0);
      drive(1'b1, w[8*k +: 8], allow_req && ($urandom_range(0, 15) == 0));
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    prog_req = 1'b0;
    @(negedge clk);
    model_reset();
    chk(name, {we_o, addr_o, wdata_o, prog_rst_no, busy_o, err_o},
        {1'b0, {AW{1'b0}}, 32'h0, 1'b0, 1'b1, 1'b0});
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          v;
    logic [7:0]    b;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          prn;
    logic          busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_row(input logic v, input logic [7:0] b, input logic we,
                                  input int addr, input logic [31:0] wd,
                                  input logic prn, input logic busy);
    vec_t r;
    r.v = v; r.b = b; r.we = we; r.addr = AW'(addr); r.wdata = wd; r.prn = prn; r.busy = busy;
    tbl.push_back(r);
  endfunction

  // Watchdog
  initial begin
    #900000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w32;

    // Two words at full rate (bytes also arrive in each write cycle),
    // then the end marker, then RUN ignoring bytes.
    add_row(1, 8'h13, 0, 0, 32'h0,        0, 1);
    add_row(1, 8'h00, 0, 0, 32'h0,        0, 1);
    add_row(1, 8'h00, 0, 0, 32'h0,        0, 1);
    add_row(1, 8'h00, 1, 0, 32'h00000013, 0, 1);
    add_row(1, 8'h93, 0, 1, 32'h0,        0, 1);
    add_row(1, 8'h00, 0, 1, 32'h0,        0, 1);
    add_row(1, 8'h10, 0, 1, 32'h0,        0, 1);
    add_row(1, 8'h00, 1, 1, 32'h00100093, 0, 1);
    add_row(1, 8'hFF, 0, 2, 32'h0,        0, 1);
    add_row(1, 8'h0F, 0, 2, 32'h0,        0, 1);
    add_row(1, 8'h00, 0, 2, 32'h0,        0, 1);
    add_row(1, 8'h00, 0, 2, 32'h0,        1, 0);
    add_row(1, 8'hAA, 0, 2, 32'h0,        1, 0);
    add_row(0, 8'h00, 0, 2, 32'h0,        1, 0);

    model_reset();
    do_reset("reset_state");

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].b, 1'b0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {we_o, addr_o, prog_rst_no, busy_o, err_o},
          {tbl[i].we, tbl[i].addr, tbl[i].prn, tbl[i].busy, 1'b0});
      if (tbl[i].we) chk($sformatf("vec%0d_wdata", i), wdata_o, tbl[i].wdata);
    end

    // Re-enter programming from RUN; a request mid-word is ignored.
    drive(1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    chk("req_enter", {prog_rst_no, busy_o, addr_o, err_o}, {1'b0, 1'b1, {AW{1'b0}}, 1'b0});
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b1);
    drive(1'b1, 8'h44, 1'b0);
    @(posedge clk);
    #1;
    chk("req_mid_word", {we_o, addr_o, wdata_o}, {1'b1, {AW{1'b0}}, 32'h44332211});
    drive(1'b0, 8'h00, 1'b0);

    // Randomized traffic with gaps, stray requests and occasional hand-off.
    for (int w = 0; w < 120; w++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_word(EM, 1'b0, 2);
        @(posedge clk);
        #1;
        chk("handoff", {prog_rst_no, busy_o, we_o}, {1'b1, 1'b0, 1'b0});
        repeat (3) drive(1'b1, 8'($urandom), 1'b0);
        drive(1'b0, 8'h00, 1'b1);
      end else begin
        w32 = $urandom;
        if (w32 == EM) w32 = w32 ^ 32'h1;
        send_word(w32, 1'b1, 2);
      end
    end
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    chk("random_drained", exp_q.size(), 0);

    // Address wrap: 4097 words at full rate from address 0.
    do_reset("reset_before_wrap");
    for (int i = 0; i < 4097; i++) begin
      send_word(32'hA500_0000 | i, 1'b0, 0);
    end
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    chk("wrap_end", {err_o, addr_o, prog_rst_no}, {1'b1, AW'(1), 1'b0});

    // Three bytes then silence past the timeout.
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h03, 1'b0);
    repeat (int'(TO) + 2) drive(1'b0, 8'h00, 1'b0);
`ifdef ICCM_PROG_TIMEOUT_EN
    m_run = 1'b1;
    m_err = 1'b1;
    m_bytes.delete();
`endif
    @(posedge clk);
    #1;
    chk("silence", {prog_rst_no, busy_o, err_o, we_o}, {m_run, ~m_run, m_err, 1'b0});

    // Reset mid-word discards the partial word.
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h66, 1'b0);
    do_reset("reset_mid_word");
    send_word(32'hEFBEADDE, 1'b0, 1);
    @(posedge clk);
    #1;
    chk("after_reset_write", {we_o, addr_o, wdata_o}, {1'b1, {AW{1'b0}}, 32'hEFBEADDE});
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    chk("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iccm_prog_ctrl.md
Name: iccm_prog_ctrl

Overview:
Programming-side controller for the instruction memory. It assembles a little-endian byte stream from the boot/UART receiver into 32-bit words. It issues single-cycle word writes on the instruction memory's programming port: addr, wdata, we. While programming, it holds the core/fabric path off via prog_rst_no. An end-of-program marker word stops programming and hands the memory back to the TL-UL path.

Parameters:
AddrW, 12, word address width of the programming port; must match the instruction memory SRAM address width.
EndMarker, 32'h0000_0FFF, assembled word that terminates programming; this word is never written.
BootInProg, 1'b1, 1: enter programming state out of reset; 0: enter run state out of reset.
TimeoutCycles, 24'd1_000_000, idle-byte timeout in clk_i cycles; used only when ICCM_PROG_TIMEOUT_EN is defined.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; synchronous, active-low
prog_req_i  input  1  single-cycle request to (re)enter programming from RUN
rx_byte_i  input  8  received program byte
rx_valid_i  input  1  rx_byte_i valid for exactly this cycle; no backpressure
we_o  output  1  programming write strobe, one cycle per word
addr_o  output  AddrW  word address of the current write
wdata_o  output  32  assembled word
prog_rst_no  output  1  0 = programming owns memory and core is held; 1 = run
busy_o  output  1  1 while in PROG or WRITE state
err_o  output  1  sticky error: address overflow, or timeout if enabled

Behaviour:
- Reset (rst_ni=0 at posedge) gives:
  - we_o=0, addr_o=0, wdata_o=0, err_o=0, byte count=0.
  - State PROG if BootInProg=1, else RUN.
  - prog_rst_no=~BootInProg; busy_o=BootInProg.
  - Reset mid-word discards the partial word.
- States: RUN, PROG, WRITE. All outputs are registered.
- RUN:
  - prog_rst_no=1, we_o=0, busy_o=0; rx_valid_i is ignored.
  - prog_req_i=1 gives, next cycle: PROG, prog_rst_no=0, addr_o=0, byte count=0, err_o cleared.
- PROG:
  - Each rx_valid_i loads rx_byte_i into word byte lane [byte count]; the first byte goes to bits [7:0].
  - Byte count is 2 bits and increments on each accepted byte.
  - 4th byte (count=3) while the assembled word != EndMarker: next cycle goes to WRITE with we_o=1, wdata_o=word, addr_o=current address.
  - 4th byte while the assembled word == EndMarker: next cycle goes to RUN with prog_rst_no=1 and busy_o=0. No write is issued and addr_o holds.
- WRITE:
  - Lasts exactly one cycle with we_o=1, then returns to PROG with we_o=0 and addr_o incremented.
  - A byte arriving in the WRITE cycle is accepted as byte 0 of the next word. No byte is lost at full rate (one byte every cycle).
- Address:
  - Increments modulo 2^AddrW.
  - The write at address 2^AddrW-1 wraps addr_o to 0 and sets err_o. err_o stays set until reset or prog_req_i. Programming continues after the wrap.
- prog_req_i in PROG or WRITE is ignored.
- A partial word (fewer than 4 bytes) is never written.

Optional Feature:
ICCM_PROG_TIMEOUT_EN
- Defined:
  - In PROG, a counter increments every cycle without rx_valid_i and clears on rx_valid_i.
  - On reaching TimeoutCycles: next cycle goes to RUN, prog_rst_no=1, err_o=1, and the partial word is discarded.
- Undefined: no counter; PROG waits indefinitely.

Test Plan:
1. Feed the 8-byte stream shown below. Required: we_o pulses at addr 0 with wdata 0x00000013, then at addr 1 with wdata 0x00100093; prog_rst_no=0 throughout.
   - Inputs: BootInProg=1, rst_ni released.
   - Bytes: 13 00 00 00 93 00 10 00.
2. Continue from scenario 1 with bytes FF 0F 00 00. Required: no we_o; prog_rst_no=1 and busy_o=0 one cycle after the last byte; addr_o stays 2.
3. Drive bytes back-to-back every cycle for 3 words, including during each we_o cycle. Required: 3 writes with correctly ordered data, no dropped bytes.
4. From RUN, pulse prog_req_i. Required: prog_rst_no=0 the next cycle and the next write lands at addr 0. A prog_req_i pulse mid-word does not reset the byte count.
5. Write 4097 words. Required: the 4097th write is at addr 0 and err_o=1 from the wrap onward.
6. Send 3 bytes, then go silent for TimeoutCycles+2 cycles.
   - With ICCM_PROG_TIMEOUT_EN: prog_rst_no=1, err_o=1, no write.
   - Without it: stays in PROG.
   - Pulse rst_ni mid-word: the partial word is discarded and all outputs return to reset values.
